irrigation_cycle_timer: RTL and testbench

Consumes the slow_clock rate output of the clock-generation stage and runs one watering cycle per request: pump priming, timed valve opening, completion and fault handling. slow_clock is sampled as a data signal in the system clock domain and converted to a one-clock tick. Outputs drive the pump/valve drivers and the status display logic.

---
 rtl/irrigation_cycle_timer.sv | 180 ++++++++++++++++++
 tb/tb_irrigation_cycle_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_cycle_timer.sv
// Irrigation cycle timer.
// Runs one watering cycle per request: pump priming, then timed valve
// opening, then a one-clock completion pulse. The slow_clock input is
// sampled as data and turned into a single-clock tick, which is the only
// timebase for the phase counters. Tank-empty and cancel abort a running
// cycle. All outputs are registered so they change on the same edge as
// the state.
module irrigation_cycle_timer #(
    parameter int SPRAY_TICKS = 20,  // watering length, sprinkler mode (1..255)
    parameter int DRIP_TICKS  = 60,  // watering length, drip mode (1..255)
    parameter int PRIME_TICKS = 2    // pump-only priming length (1..15)
) (
    input  logic       clock,
    input  logic       reset,       // asynchronous, active-low
    input  logic       slow_clock,
    input  logic       soil_dry,
    input  logic       tank_empty,
    input  logic       drip_mode,
    input  logic       cancel,
    output logic       pump_on,
    output logic       valve_open,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remaining
);

    localparam logic [7:0] L_SPRAY = 8'(SPRAY_TICKS);
    localparam logic [7:0] L_DRIP  = 8'(DRIP_TICKS);
    localparam logic [7:0] L_PRIME = 8'(PRIME_TICKS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_WATER  = 3'd2,
        S_FINISH = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic       w_tick;
    logic       r_mode;
    logic       w_next_mode;
    logic [7:0] r_remaining;
    logic [7:0] w_next_rem;
    logic       r_pump;
    logic       r_valve;
    logic       r_busy;
    logic       r_done;
    logic       r_fault;
    logic       w_next_pump;
    logic       w_next_valve;
    logic       w_next_busy;
    logic       w_next_done;
    logic       w_next_fault;

    // Two-flop synchroniser on slow_clock plus an edge flop for rise detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= slow_clock;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // One-clock pulse per synchronised rising edge; falling edges give nothing.
    assign w_tick = r_s2 & ~r_s3;

    // Next-state, phase counter and next-output decode.
    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_remaining;
        w_next_mode  = r_mode;
        case (r_state)
            S_IDLE: begin
                w_next_rem = 8'd0;
                if (soil_dry && !tank_empty && !cancel) begin
                    w_next_mode  = drip_mode;
                    w_next_rem   = L_PRIME;
                    w_next_state = S_PRIME;
                end else if (soil_dry && tank_empty) begin
                    w_next_state = S_FAULT;
                end
            end
            S_PRIME: begin
                // Aborts outrank a coincident tick; an empty tank outranks cancel.
                if (tank_empty) begin
                    w_next_state = S_FAULT;
                    w_next_rem   = 8'd0;
                end else if (cancel) begin
                    w_next_state = S_IDLE;
                    w_next_rem   = 8'd0;
                end else if (w_tick) begin
                    if (r_remaining == 8'd1) begin
                        w_next_rem   = r_mode ? L_DRIP : L_SPRAY;
                        w_next_state = S_WATER;
                    end else if (r_remaining != 8'd0) begin
                        w_next_rem = r_remaining - 8'd1;
                    end
                end
            end
            S_WATER: begin
                // soil_dry is deliberately ignored here: a started cycle runs to the end.
                if (tank_empty) begin
                    w_next_state = S_FAULT;
                    w_next_rem   = 8'd0;
                end else if (cancel) begin
                    w_next_state = S_IDLE;
                    w_next_rem   = 8'd0;
                end else if (w_tick) begin
                    if (r_remaining == 8'd1) begin
                        w_next_rem   = 8'd0;
                        w_next_state = S_FINISH;
                    end else if (r_remaining != 8'd0) begin
                        w_next_rem = r_remaining - 8'd1;
                    end
                end
            end
            S_FINISH: begin
                w_next_rem   = 8'd0;
                w_next_state = S_IDLE;
            end
            S_FAULT: begin
                w_next_rem = 8'd0;
                if (cancel && !tank_empty) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_rem   = 8'd0;
            end
        endcase

        w_next_pump  = (w_next_state == S_PRIME) || (w_next_state == S_WATER);
        w_next_valve = (w_next_state == S_WATER);
        w_next_busy  = (w_next_state == S_PRIME) || (w_next_state == S_WATER);
        w_next_done  = (w_next_state == S_FINISH);
        w_next_fault = (w_next_state == S_FAULT);
    end

    // State, latched mode, counter and registered outputs; reset drops drives at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_remaining <= 8'd0;
            r_pump      <= 1'b0;
            r_valve     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mode      <= w_next_mode;
            r_remaining <= w_next_rem;
            r_pump      <= w_next_pump;
            r_valve     <= w_next_valve;
            r_busy      <= w_next_busy;
            r_done      <= w_next_done;
            r_fault     <= w_next_fault;
        end
    end

    assign pump_on    = r_pump;
    assign valve_open = r_valve;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign remaining  = r_remaining;

endmodule

// File: tb/tb_irrigation_cycle_timer.sv
// Bench for irrigation_cycle_timer with PRIME=2, SPRAY=3, DRIP=5.
// A per-clock vector table covers a full spray cycle; hand-written
// sequences cover reset, drip latching, tick timing, faults and cancel.
module tb_irrigation_cycle_timer;

    logic       clock;
    logic       reset;
    logic       slow_clock;
    logic       soil_dry;
    logic       tank_empty;
    logic       drip_mode;
    logic       cancel;
    logic       pump_on;
    logic       valve_open;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] remaining;

    int checks;
    int errors;
    int done_cnt;
    int ph;

    typedef struct {
        logic       slow;
        logic       soil;
        logic       tank;
        logic       drip;
        logic       cncl;
        logic       e_pump;
        logic       e_valve;
        logic       e_busy;
        logic       e_done;
        logic       e_fault;
        logic [7:0] e_rem;
    } vec_t;

    vec_t tbl [22];

    irrigation_cycle_timer #(
        .SPRAY_TICKS(3),
        .DRIP_TICKS (5),
        .PRIME_TICKS(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .slow_clock(slow_clock),
        .soil_dry  (soil_dry),
        .tank_empty(tank_empty),
        .drip_mode (drip_mode),
        .cancel    (cancel),
        .pump_on   (pump_on),
        .valve_open(valve_open),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .remaining (remaining)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && done) done_cnt++;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic v, input logic b,
                           input logic d, input logic f, input logic [7:0] r);
        chk({tag, " pump_on"},    {7'd0, pump_on},    {7'd0, p});
        chk({tag, " valve_open"}, {7'd0, valve_open}, {7'd0, v});
        chk({tag, " busy"},       {7'd0, busy},       {7'd0, b});
        chk({tag, " done"},       {7'd0, done},       {7'd0, d});
        chk({tag, " fault"},      {7'd0, fault},      {7'd0, f});
        chk({tag, " remaining"},  remaining,          r);
    endtask

    // One clock: inputs already driven, sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Fast slow_clock pattern 0,1,1,0 repeating, so a tick is acted on every 4th clock.
    task automatic fast_step(input logic soil, input logic tank, input logic cncl);
        slow_clock = (ph % 4 == 1) || (ph % 4 == 2);
        soil_dry   = soil;
        tank_empty = tank;
        cancel     = cncl;
        ph++;
        step();
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset      = 1'b0;
        slow_clock = 1'b0;
        soil_dry   = 1'b0;
        tank_empty = 1'b0;
        drip_mode  = 1'b0;
        cancel     = 1'b0;
        ph         = 0;
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One 7-high/7-low slow_clock period; reports how often and when remaining changed.
    task automatic run_period(output int nchg, output int chg_at);
        logic [7:0] prev;
        nchg   = 0;
        chg_at = 0;
        for (int i = 1; i <= 14; i++) begin
            prev       = remaining;
            slow_clock = (i <= 7);
            step();
            if (remaining != prev) begin
                nchg++;
                chg_at = i;
            end
        end
    endtask

    initial begin
        int n;
        int at;
        int dc0;
        logic [7:0] exp_rem [7];
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        ph       = 0;

        // Reset state before any clock edge.
        reset      = 1'b0;
        slow_clock = 1'b0;
        soil_dry   = 1'b0;
        tank_empty = 1'b0;
        drip_mode  = 1'b0;
        cancel     = 1'b0;
        #2;
        chk_out("power-on reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset = 1'b1;

        // ---- Table: normal spray cycle, soil_dry dropped mid-WATER ----
        //            slow soil tank drip cncl  pump valve busy done fault rem
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 22; i++) begin
            slow_clock = tbl[i].slow;
            soil_dry   = tbl[i].soil;
            tank_empty = tbl[i].tank;
            drip_mode  = tbl[i].drip;
            cancel     = tbl[i].cncl;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].e_pump, tbl[i].e_valve, tbl[i].e_busy,
                    tbl[i].e_done, tbl[i].e_fault, tbl[i].e_rem);
        end
        chk("spray done pulses", 8'(done_cnt), 8'd1);

        // ---- Reset asserted mid-WATER drops drives without a clock edge ----
        apply_reset();
        for (int i = 0; i < 9; i++) fast_step(1'b1, 1'b0, 1'b0);
        chk_out("pre-reset water", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        #2;
        reset = 1'b0;
        #1;
        chk_out("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset = 1'b1;
        ph    = 0;
        for (int i = 0; i < 10; i++) begin
            fast_step(1'b0, 1'b0, 1'b0);
            chk($sformatf("idle after reset busy %0d", i), {7'd0, busy}, 8'd0);
        end
        chk("idle after reset remaining", remaining, 8'd0);

        // ---- Drip mode latched at start; 7-high/7-low tick timing ----
        apply_reset();
        dc0        = done_cnt;
        soil_dry   = 1'b1;
        drip_mode  = 1'b1;
        slow_clock = 1'b0;
        step();
        chk_out("drip start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        drip_mode = 1'b0;
        exp_rem = '{8'd1, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        for (int p = 0; p < 7; p++) begin
            run_period(n, at);
            chk($sformatf("period%0d changes", p), 8'(n), 8'd1);
            chk($sformatf("period%0d tick position", p), 8'(at), 8'd3);
            chk($sformatf("period%0d remaining", p), remaining, exp_rem[p]);
            if (p == 0) begin
                chk("drip p0 valve", {7'd0, valve_open}, 8'd0);
                soil_dry = 1'b0;
            end
            if (p == 1) chk("drip p1 valve", {7'd0, valve_open}, 8'd1);
        end
        chk_out("drip end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("drip done pulses", 8'(done_cnt - dc0), 8'd1);

        // ---- Tank empties in WATER on a tick clock ----
        apply_reset();
        dc0 = done_cnt;
        for (int i = 0; i < 11; i++) fast_step(1'b1, 1'b0, 1'b0);
        chk_out("water before fault", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        fast_step(1'b1, 1'b1, 1'b0);
        chk_out("tank empty fault", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        fast_step(1'b0, 1'b1, 1'b1);
        chk_out("cancel while empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        fast_step(1'b0, 1'b0, 1'b1);
        chk_out("fault cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        fast_step(1'b0, 1'b0, 1'b0);
        chk_out("idle after fault", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("fault done pulses", 8'(done_cnt - dc0), 8'd0);

        // ---- Cancel during PRIME, restart, then abort priority ----
        apply_reset();
        dc0 = done_cnt;
        fast_step(1'b1, 1'b0, 1'b0);
        chk_out("prime", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        fast_step(1'b1, 1'b0, 1'b1);
        chk_out("cancel in prime", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        fast_step(1'b1, 1'b0, 1'b0);
        chk_out("restart prime", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        fast_step(1'b1, 1'b1, 1'b1);
        chk_out("fault beats cancel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("cancel done pulses", 8'(done_cnt - dc0), 8'd0);

        // ---- IDLE with dry soil and empty tank goes straight to FAULT ----
        apply_reset();
        fast_step(1'b1, 1'b1, 1'b0);
        chk_out("idle to fault", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
